wb_rr_arbiter: RTL and testbench

- N-master to 1-slave Wishbone arbiter between the cache masters (icache, dcache, future prefetch/DMA) and the shared DRAM slave port.
- Generalises the fixed two-port icache/dcache interconnect:
  - parametrised master count and bus widths;
  - registered round-robin fairness;
  - deterministic idle outputs;
  - explicit handling of master abort and slave retry.

---
 rtl/wb_rr_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: N-master to 1-slave Wishbone round-robin arbiter.
// Define WB_RR_ARBITER_TIMEOUT_EN to add the per-grant watchdog retry.
module wb_rr_arbiter #(
  parameter int NUM_M   = 2,
  parameter int ADR_W   = 32,
  parameter int DATA_W  = 128,
  parameter int SEL_W   = DATA_W / 8,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_M-1:0]          m_cyc,
  input  logic [NUM_M-1:0]          m_stb,
  input  logic [NUM_M-1:0]          m_we,
  input  logic [NUM_M*SEL_W-1:0]    m_sel,
  input  logic [NUM_M*ADR_W-1:0]    m_adr,
  input  logic [NUM_M*DATA_W-1:0]   m_dat_m,
  output logic [NUM_M-1:0]          m_ack,
  output logic [NUM_M-1:0]          m_rty,
  output logic [NUM_M*DATA_W-1:0]   m_dat_s,
  output logic                      s_cyc,
  output logic                      s_stb,
  output logic                      s_we,
  output logic [SEL_W-1:0]          s_sel,
  output logic [ADR_W-1:0]          s_adr,
  output logic [DATA_W-1:0]         s_dat_m,
  input  logic                      s_ack,
  input  logic                      s_rty,
  input  logic [DATA_W-1:0]         s_dat_s,
  output logic [NUM_M-1:0]          grant
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_M-1:0] grant_q, grant_d;

  logic [NUM_M-1:0] req;
  logic             lo_vld, hi_vld;
  logic [IW-1:0]    lo_idx, hi_idx;
  logic             pick_vld;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    nxt_ptr;

  logic              own_cyc, own_stb, own_we;
  logic [SEL_W-1:0]  own_sel;
  logic [ADR_W-1:0]  own_adr;
  logic [DATA_W-1:0] own_dat;

  logic in_grant;
  logic tmo_hit;
  logic end_xfer;

  assign req      = m_cyc & m_stb;
  assign in_grant = (state_q == ST_GRANT);
  assign grant    = grant_q;

  // Round-robin pick: lowest requester at/after rr_ptr, else lowest overall
  always_comb begin
    lo_vld = 1'b0;
    hi_vld = 1'b0;
    lo_idx = '0;
    hi_idx = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_vld = 1'b1;
        lo_idx = IW'(i);
        if (i >= int'(rr_ptr_q)) begin
          hi_vld = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
    pick_vld = lo_vld;
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  // Select the current owner's request signals
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (owner_q == IW'(i)) begin
        own_cyc = m_cyc[i];
        own_stb = m_stb[i];
        own_we  = m_we[i];
        own_sel = m_sel[i*SEL_W +: SEL_W];
        own_adr = m_adr[i*ADR_W +: ADR_W];
        own_dat = m_dat_m[i*DATA_W +: DATA_W];
      end
    end
  end

  assign nxt_ptr = (owner_q == IW'(NUM_M - 1)) ? '0
                 : owner_q + IW'(1);

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = in_grant && own_cyc && !s_ack && !s_rty
                && (tmo_cnt_q == TW'(TIMEOUT - 1));

  // Watchdog: held at zero outside GRANT, counts stalled GRANT cycles
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (!in_grant) begin
      tmo_cnt_d = '0;
    end else if (!(s_ack || s_rty)) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end
`else
  // Watchdog compiled out; never fires for any legal TIMEOUT
  assign tmo_hit = (TIMEOUT < 0);
`endif

  assign end_xfer = s_ack || s_rty || !own_cyc || tmo_hit;

  // Next-state, owner and round-robin pointer
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ST_IDLE, ST_RELEASE: begin
        if (pick_vld) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (end_xfer) begin
          state_d  = ST_RELEASE;
          rr_ptr_d = nxt_ptr;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    grant_d = '0;
    for (int i = 0; i < NUM_M; i++) begin
      grant_d[i] = (state_d == ST_GRANT)
                && (owner_d == IW'(i));
    end
  end

  // Route owner to slave and slave response back to owner only
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_sel   = '0;
    s_adr   = '0;
    s_dat_m = '0;
    m_ack   = '0;
    m_rty   = '0;
    m_dat_s = '0;
    if (in_grant) begin
      s_cyc   = own_cyc && !tmo_hit;
      s_stb   = own_cyc && own_stb && !tmo_hit;
      s_we    = own_we;
      s_sel   = own_sel;
      s_adr   = own_adr;
      s_dat_m = own_dat;
      for (int i = 0; i < NUM_M; i++) begin
        if ((owner_q == IW'(i)) && own_cyc) begin
          m_ack[i] = s_ack;
          m_rty[i] = s_rty || tmo_hit;
          m_dat_s[i*DATA_W +: DATA_W] = s_dat_s;
        end
      end
    end
  end

  // Arbiter state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed scoreboard bench for wb_rr_arbiter.
// Four masters, 32-bit data, 16-bit address, default build.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct {
    logic [NM-1:0] g;
    int            gap;
  } gexp_t;

  typedef struct {
    logic [NM-1:0]    ack;
    logic [NM-1:0]    rty;
    logic [NM*DW-1:0] dat;
  } rexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*SW-1:0] m_sel;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat_m;
  logic [NM-1:0]    m_ack, m_rty;
  logic [NM*DW-1:0] m_dat_s;
  logic             s_cyc, s_stb, s_we;
  logic [SW-1:0]    s_sel;
  logic [AW-1:0]    s_adr;
  logic [DW-1:0]    s_dat_m;
  logic             s_ack, s_rty;
  logic [DW-1:0]    s_dat_s;
  logic [NM-1:0]    grant;

  wb_rr_arbiter #(
    .NUM_M (NM),
    .ADR_W (AW),
    .DATA_W(DW),
    .SEL_W (SW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .m_cyc  (m_cyc),
    .m_stb  (m_stb),
    .m_we   (m_we),
    .m_sel  (m_sel),
    .m_adr  (m_adr),
    .m_dat_m(m_dat_m),
    .m_ack  (m_ack),
    .m_rty  (m_rty),
    .m_dat_s(m_dat_s),
    .s_cyc  (s_cyc),
    .s_stb  (s_stb),
    .s_we   (s_we),
    .s_sel  (s_sel),
    .s_adr  (s_adr),
    .s_dat_m(s_dat_m),
    .s_ack  (s_ack),
    .s_rty  (s_rty),
    .s_dat_s(s_dat_s),
    .grant  (grant)
  );

  int n_chk  = 0;
  int n_fail = 0;

  gexp_t exp_g[$];
  rexp_t exp_r[$];

  int            pend[NM];
  logic [NM-1:0] stb_off;
  logic [NM-1:0] ack_seen;
  int            zcnt;

  int          slv_mode;
  int          slv_lat;
  logic        slv_fix;
  logic [DW-1:0] slv_dat;

  function automatic logic [AW-1:0] adr_of(input int i);
    return AW'(16'h1000 * (i + 1));
  endfunction

  function automatic logic [DW-1:0] wdat_of(input int i);
    return 32'hC0DE_0000 | DW'(i);
  endfunction

  function automatic logic [SW-1:0] sel_of(input int i);
    return (i % 2 == 1) ? 4'h3 : 4'hC;
  endfunction

  function automatic logic [NM*DW-1:0] exp_dat(input int i,
                                               input logic [DW-1:0] v);
    logic [NM*DW-1:0] r;
    r = '0;
    r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_g(input int i, input int gap);
    gexp_t e;
    e.g      = '0;
    e.g[i]   = 1'b1;
    e.gap    = gap;
    exp_g.push_back(e);
  endtask

  task automatic push_r(input int i, input logic [DW-1:0] v);
    rexp_t e;
    e.ack    = '0;
    e.ack[i] = 1'b1;
    e.rty    = '0;
    e.dat    = exp_dat(i, v);
    exp_r.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < NM; i++) begin
      m_cyc[i] = (pend[i] > 0);
      m_stb[i] = (pend[i] > 0) && !stb_off[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NM; i++) begin
      if (ack_seen[i] && m_cyc[i] && pend[i] > 0) pend[i]--;
    end
    drive();
  endtask

  function automatic logic all_idle();
    logic b;
    b = (grant == '0);
    for (int i = 0; i < NM; i++) if (pend[i] != 0) b = 1'b0;
    return b;
  endfunction

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!all_idle() && n < maxc);
    check("wait_bound", 128'(n < maxc), 128'(1));
    tick();
    tick();
  endtask

  // Slave model: ack after slv_lat strobed cycles; data tagged by address
  initial begin
    s_ack   = 1'b0;
    s_rty   = 1'b0;
    s_dat_s = '0;
    forever begin : slv
      int scnt;
      scnt = 0;
      forever begin
        @(posedge clk);
        #2;
        s_ack   = 1'b0;
        s_dat_s = '0;
        if (slv_mode == 2) begin
          s_ack   = 1'b1;
          s_dat_s = 32'hBAD0_0BAD;
        end else if (slv_mode == 0 && s_cyc && s_stb) begin
          if (scnt == slv_lat) begin
            s_ack   = 1'b1;
            s_dat_s = slv_fix ? slv_dat : {16'hA5A5, s_adr};
            scnt    = 0;
          end else begin
            scnt++;
          end
        end else begin
          scnt = 0;
        end
      end
    end
  end

  // Monitor: invariants each cycle, scoreboard pops on grant/response
  initial begin
    logic [NM-1:0] prev_g;
    ack_seen = '0;
    zcnt     = 0;
    prev_g   = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      ack_seen = m_ack | m_rty;
      if (grant == '0) begin
        check("idle_outputs",
              128'(|{s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_m,
                     m_ack, m_rty, m_dat_s}),
              128'(0));
      end else begin
        check("grant_onehot", 128'($onehot(grant)), 128'(1));
        for (int i = 0; i < NM; i++) begin
          if (grant[i]) begin
            check("route_cyc", 128'(s_cyc), 128'(m_cyc[i]));
            check("route_stb", 128'(s_stb), 128'(m_cyc[i] & m_stb[i]));
            check("route_we", 128'(s_we), 128'(m_we[i]));
            check("route_sel", 128'(s_sel), 128'(sel_of(i)));
            check("route_adr", 128'(s_adr), 128'(adr_of(i)));
            check("route_dat", 128'(s_dat_m), 128'(wdat_of(i)));
          end
        end
        if (grant != prev_g) begin
          if (exp_g.size() == 0) begin
            check("grant_unexp", 128'(grant), 128'(0));
          end else begin
            gexp_t e;
            e = exp_g.pop_front();
            check("grant_seq", 128'(grant), 128'(e.g));
            if (e.gap >= 0)
              check("grant_gap", 128'(zcnt), 128'(e.gap));
          end
        end
      end
      if ((m_ack | m_rty) != '0) begin
        if (exp_r.size() == 0) begin
          check("resp_unexp", 128'(m_ack | m_rty), 128'(0));
        end else begin
          rexp_t r;
          r = exp_r.pop_front();
          check("resp_ack", 128'(m_ack), 128'(r.ack));
          check("resp_rty", 128'(m_rty), 128'(r.rty));
          check("resp_dat", 128'(m_dat_s), 128'(r.dat));
        end
      end
      if (!rst_n || grant != '0) zcnt = 0;
      else zcnt++;
      prev_g = grant;
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    rst_n    = 1'b0;
    slv_mode = 0;
    slv_lat  = 0;
    slv_fix  = 1'b0;
    slv_dat  = '0;
    stb_off  = '0;
    m_we     = '0;
    for (int i = 0; i < NM; i++) begin
      m_sel[i*SW +: SW]   = sel_of(i);
      m_adr[i*AW +: AW]   = adr_of(i);
      m_dat_m[i*DW +: DW] = wdat_of(i);
      pend[i] = 1;
    end
    drive();

    // reset with all masters requesting, then one pass round the ring
    push_g(0, 1);
    push_g(1, 1);
    push_g(2, 1);
    push_g(3, 1);
    push_r(0, 32'hA5A5_1000);
    push_r(1, 32'hA5A5_2000);
    push_r(2, 32'hA5A5_3000);
    push_r(3, 32'hA5A5_4000);
    tick();
    tick();
    rst_n = 1'b1;
    wait_done(200);

    // contention between masters 0 and 1, slave latency 3
    slv_lat = 3;
    push_g(0, -1);
    push_g(1, 1);
    push_g(0, 1);
    push_g(1, 1);
    push_r(0, 32'hA5A5_1000);
    push_r(1, 32'hA5A5_2000);
    push_r(0, 32'hA5A5_1000);
    push_r(1, 32'hA5A5_2000);
    pend[0] = 2;
    pend[1] = 2;
    drive();
    wait_done(200);

    // isolation: master 1 write, fixed read data
    slv_lat = 1;
    slv_fix = 1'b1;
    slv_dat = 32'hDEAD_BEEF;
    m_we[1] = 1'b1;
    push_g(1, -1);
    push_r(1, 32'hDEAD_BEEF);
    pend[1] = 1;
    drive();
    wait_done(200);
    slv_fix = 1'b0;
    m_we[1] = 1'b0;

    // abort by owner 0 in GRANT cycle 2, late ack in RELEASE
    slv_mode = 1;
    push_g(0, -1);
    pend[0] = 1;
    drive();
    tick();
    tick();
    pend[0] = 0;
    drive();
    #3;
    check("abort_scyc", 128'(s_cyc), 128'(0));
    check("abort_grant", 128'(grant), 128'(4'b0001));
    tick();
    slv_mode = 2;
    #3;
    check("abort_release", 128'(grant), 128'(0));
    tick();
    slv_mode = 1;
    tick();
    slv_mode = 0;
    slv_lat  = 0;
    push_g(1, -1);
    push_g(0, 1);
    push_r(1, 32'hA5A5_2000);
    push_r(0, 32'hA5A5_1000);
    pend[0] = 1;
    pend[1] = 1;
    drive();
    wait_done(200);

    // bus lock: owner 2 drops stb but keeps cyc
    slv_mode = 1;
    push_g(2, -1);
    push_r(2, 32'hA5A5_3000);
    pend[2] = 1;
    drive();
    tick();
    tick();
    stb_off[2] = 1'b1;
    drive();
    #3;
    check("lock_grant", 128'(grant), 128'(4'b0100));
    check("lock_scyc", 128'(s_cyc), 128'(1));
    check("lock_sstb", 128'(s_stb), 128'(0));
    tick();
    stb_off[2] = 1'b0;
    drive();
    slv_mode = 0;
    wait_done(200);

    // wrap: rr_ptr at 3, masters 3 and 1 request
    push_g(3, -1);
    push_g(1, 1);
    push_g(3, 1);
    push_r(3, 32'hA5A5_4000);
    push_r(1, 32'hA5A5_2000);
    push_r(3, 32'hA5A5_4000);
    pend[3] = 2;
    pend[1] = 1;
    drive();
    wait_done(200);

    // pointer wrapped to 0: master 0 beats master 3
    push_g(0, -1);
    push_g(3, 1);
    push_r(0, 32'hA5A5_1000);
    push_r(3, 32'hA5A5_4000);
    pend[0] = 1;
    pend[3] = 1;
    drive();
    wait_done(200);

    tick();
    tick();
    check("grant_q_left", 128'(exp_g.size()), 128'(0));
    check("resp_q_left", 128'(exp_r.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
